ahb_slave_mem: RTL
==================

# ahb_slave_mem

AHB-Lite memory slave that sits directly downstream of the AHB master through the shared bus, consuming its address/control/write-data and returning ready, response and read data. Provides a word-organised on-chip store with programmable wait states, byte/halfword/word access, and the two-cycle ERROR response for illegal accesses. It is the default target for master bring-up and burst testing.

## Interface
- DEPTH_LOG2, 6: log2 of word count; store holds 2^DEPTH_LOG2 32-bit words.
- WAIT_STATES, 1: HREADY-low cycles inserted in every OKAY data phase; 0..7.
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- dec_ahbs_HSEL  in  1  slave select from address decoder.
- ahb_HREADYin  in  1  bus-level HREADY; address phase is sampled only when high.
- ahbm_HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- ahbm_HADDR  in  32  byte address.
- ahbm_ahbs_HWRITE  in  1  1=write.
- ahbm_ahbs_HSIZE  in  3  0=byte, 1=halfword, 2=word; others illegal.
- ahbm_HBURST  in  3  burst type; accepted, not used for decode.
- ahbm_HPROT  in  4  protection; accepted, not used.
- ahbm_ahbs_HWDATA  in  32  write data, valid in data phase.
- ahbs_HREADY  out  1  slave ready (HREADYOUT).
- ahbs_HRESP  out  2  OKAY=0, ERROR=1.
- ahbs_ahbm_HRDATA  out  32  read data.

## Operation
- Transfer accepted when dec_ahbs_HSEL & ahb_HREADYin & ahbm_HTRANS[1]; captured into address-phase registers (addr, write, size, error flag).
- IDLE/BUSY or unselected: no capture; next data phase is OKAY, zero wait.
- Illegal: word address ≥ 2^DEPTH_LOG2; HSIZE > 2; halfword with HADDR[0]=1; word with HADDR[1:0]≠0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=OKAY. Legal capture → WAIT if WAIT_STATES>0, else stay (zero-wait data phase completes next cycle). Illegal capture → ERR1.
  - WAIT: HREADY=0, OKAY; counter loads WAIT_STATES-1 on entry, decrements; at 0 → IDLE (next cycle completes the data phase with HREADY=1).
  - ERR1: HREADY=0, HRESP=ERROR → ERR2 unconditionally.
  - ERR2: HREADY=1, HRESP=ERROR; new address phase may be sampled here → next state per decode of that transfer.
- Writes commit at the rising edge ending the data phase (HREADY=1), byte enables from size and addr[1:0], little-endian lanes. Errored writes never modify storage.
- Reads: HRDATA = store[captured word addr] during the completing data-phase cycle; 0 at all other times and for errored reads.
- Read immediately after write to same word returns the new value (write committed before read data phase).
- Master issuing IDLE during ERR2 (burst cancel) → IDLE, OKAY.

## Timing
- Reset: ahbs_HREADY=1, ahbs_HRESP=OKAY, ahbs_ahbm_HRDATA=0, FSM=IDLE, counter=0, captured transfer invalid; storage contents undefined (not reset).
- Reset asserted mid-data-phase: pending write dropped, outputs to reset values asynchronously.
- OKAY data phase length = WAIT_STATES+1 cycles; ERROR data phase = 2 cycles.
- Pipelined: next address phase overlaps current data phase; sampled only on its final (HREADY=1) cycle.
- BUSY inside a burst: zero-wait OKAY, no storage access.

## Structure
- ahb_pkg: HTRANS, HRESP, HSIZE encodings and FSM state enum.
- Sub-module ahb_slave_mem_array: 2^DEPTH_LOG2 × 32 store, 4-bit byte-enable synchronous write, asynchronous read.
- Top: address-phase capture, decode, FSM, wait counter, lane/enable generation.

## Test plan
- WAIT_STATES=1: write 0xDEADBEEF to 0x10, read 0x10 → write phase 2 cycles OKAY; read HRDATA=0xDEADBEEF on 2nd data cycle.
- Byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
- Word read at 0x102 (misaligned) → HREADY=0/ERROR then HREADY=1/ERROR, HRDATA=0; store unchanged.
- WAIT_STATES=0, 4-beat INCR4 write 0x20..0x2C with a BUSY after beat 2 → each beat 1 cycle OKAY, BUSY cycle OKAY, all 4 words correct.
- Write to word address 2^DEPTH_LOG2 with IDLE during ERR2 → ERROR pair then IDLE/OKAY; no write.
- Assert HRESETn low during WAIT of a write to 0x04 → outputs at reset values immediately; 0x04 retains prior value.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and slave FSM states shared by the memory slave.
package ahb_pkg;
   localparam logic [1:0] HRESP_OKAY  = 2'd0;
   localparam logic [1:0] HRESP_ERROR = 2'd1;
   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_e;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;
endpackage

// File: rtl/ahb_slave_mem_array.sv
// ahb_slave_mem_array: 32-bit word store with byte-enable synchronous write and asynchronous read.
module ahb_slave_mem_array #(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [2**DEPTH_LOG2];
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
   assign rdata = mem[addr];
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory slave with programmable wait states and two-cycle ERROR response.
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        dec_ahbs_HSEL,
   input  logic        ahb_HREADYin,
   input  logic [1:0]  ahbm_HTRANS,
   input  logic [31:0] ahbm_HADDR,
   input  logic        ahbm_ahbs_HWRITE,
   input  logic [2:0]  ahbm_ahbs_HSIZE,
   input  logic [2:0]  ahbm_HBURST,
   input  logic [3:0]  ahbm_HPROT,
   input  logic [31:0] ahbm_ahbs_HWDATA,
   output logic        ahbs_HREADY,
   output logic [1:0]  ahbs_HRESP,
   output logic [31:0] ahbs_ahbm_HRDATA
);
   state_e                state, nxt, decoded;
   logic [2:0]            cnt;
   logic                  accept, illegal, hready, done, dp_valid, dp_write;
   logic [DEPTH_LOG2-1:0] dp_addr;
   logic [3:0]            be, dp_be;
   logic [31:0]           rdata;
   logic                  unused_ok;
   assign unused_ok = &{1'b0, ahbm_HBURST, ahbm_HPROT, ahbm_HTRANS[0]};
   assign accept  = dec_ahbs_HSEL & ahb_HREADYin & ahbm_HTRANS[1];
   assign illegal = (|ahbm_HADDR[31:DEPTH_LOG2+2]) || (ahbm_ahbs_HSIZE > HSIZE_WORD) ||
                    (ahbm_ahbs_HSIZE == HSIZE_HALF && ahbm_HADDR[0]) ||
                    (ahbm_ahbs_HSIZE == HSIZE_WORD && |ahbm_HADDR[1:0]);
   always_comb begin
      be      = ahbm_ahbs_HSIZE == HSIZE_BYTE ? 4'b0001 << ahbm_HADDR[1:0] :
                ahbm_ahbs_HSIZE == HSIZE_HALF ? (ahbm_HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      decoded = !accept ? ST_IDLE : illegal ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
      nxt     = state == ST_WAIT ? (cnt == 3'd0 ? ST_IDLE : ST_WAIT) :
                state == ST_ERR1 ? ST_ERR2 : decoded;
   end
   assign hready           = state != ST_WAIT && state != ST_ERR1;
   // an OKAY data phase always completes in IDLE, the only OKAY state with HREADY high
   assign done             = state == ST_IDLE && dp_valid;
   assign ahbs_HREADY      = hready;
   assign ahbs_HRESP       = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   assign ahbs_ahbm_HRDATA = (done && !dp_write) ? rdata : 32'h0;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state    <= ST_IDLE;
         cnt      <= 3'd0;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_be    <= 4'h0;
      end else begin
         state <= nxt;
         if (nxt == ST_WAIT && state != ST_WAIT) cnt <= 3'(WAIT_STATES - 1);
         else if (state == ST_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
         if (hready) begin
            dp_valid <= accept && !illegal;
            dp_write <= ahbm_ahbs_HWRITE;
            dp_addr  <= ahbm_HADDR[DEPTH_LOG2+1:2];
            dp_be    <= be;
         end
      end
   ahb_slave_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk  (HCLK),
      .we   (done && dp_write),
      .be   (dp_be),
      .addr (dp_addr),
      .wdata(ahbm_ahbs_HWDATA),
      .rdata(rdata)
   );
endmodule
